// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add unsigned multiplier with a start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as no multiplier bits remain.
module mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, mplr;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [CW-1:0] cnt;
  logic accept, last;
  always_comb begin
    acc_n = acc + (mplr[0] ? ({{WIDTH{1'b0}}, mcand} << (CW'(WIDTH) - cnt)) : '0);
`ifdef MUL_EARLY_TERM_EN
    last = (cnt == CW'(1)) || ((mplr >> 1) == '0);
`else
    last = cnt == CW'(1);
`endif
    accept = start && state != RUN;
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr <= '0;
      acc <= '0;
      cnt <= '0;
      out <= '0;
    end else if (accept) begin
      mcand <= in1;
      mplr <= in2;
      acc <= '0;
      cnt <= CW'(WIDTH);
    end else if (state == RUN) begin
      acc <= acc_n;
      mplr <= mplr >> 1;
      cnt <= cnt - CW'(1);
      if (last) out <= acc_n;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
